// File: rtl/sobel_edge_3x3_8bit_pkg.sv
// Shared image-process constants and helpers
// for the 3x3 Sobel edge stage.
package sobel_edge_3x3_8bit_pkg;

    localparam int PIX_W       = 8;
    localparam int SOBEL_SUM_W = 10;
    localparam int SOBEL_MAG_W = 11;
    localparam int BORDER      = 2;
    localparam int SYNC_W      = 3;
    localparam int PIPE_LAT    = 3;

    typedef struct packed {
        logic vsync;
        logic href;
        logic clken;
    } sync_t;

    // a + 2*m + b, widened so 4*255 fits
    function automatic logic [SOBEL_SUM_W-1:0] tap_sum(
        input logic [PIX_W-1:0] a,
        input logic [PIX_W-1:0] m,
        input logic [PIX_W-1:0] b
    );
        return {2'b00, a} + {1'b0, m, 1'b0} + {2'b00, b};
    endfunction

    // |a - b| as larger minus smaller
    function automatic logic [SOBEL_SUM_W-1:0] abs_diff(
        input logic [SOBEL_SUM_W-1:0] a,
        input logic [SOBEL_SUM_W-1:0] b
    );
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/sobel_edge_3x3_8bit_sync_delay_line.sv
// Parametric width/depth shift register used to
// keep sync and border flags aligned with the datapath.
module sync_delay_line #(
    parameter int W = 1,
    parameter int D = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] stage_q [D];
    logic [W-1:0] stage_d [D];

    // next value of each tap: shift one place per clk
    always_comb begin
        stage_d[0] = d;
        for (int i = 1; i < D; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // tap registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < D; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < D; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign q = stage_q[D-1];

endmodule

// File: rtl/sobel_edge_3x3_8bit.sv
// Sobel |Gx|+|Gy| edge detector on a 3x3 window stream,
// 3-clk free-running pipeline with border suppression.
module sobel_edge_3x3_8bit
    import sobel_edge_3x3_8bit_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   matrix_frame_vsync,
    input  logic                   matrix_frame_href,
    input  logic                   matrix_frame_clken,
    input  logic [PIX_W-1:0]       matrix_p11,
    input  logic [PIX_W-1:0]       matrix_p12,
    input  logic [PIX_W-1:0]       matrix_p13,
    input  logic [PIX_W-1:0]       matrix_p21,
    input  logic [PIX_W-1:0]       matrix_p22,
    input  logic [PIX_W-1:0]       matrix_p23,
    input  logic [PIX_W-1:0]       matrix_p31,
    input  logic [PIX_W-1:0]       matrix_p32,
    input  logic [PIX_W-1:0]       matrix_p33,
    input  logic [SOBEL_MAG_W-1:0] threshold,
    output logic                   post_frame_vsync,
    output logic                   post_frame_href,
    output logic                   post_frame_clken,
    output logic                   post_img_bit,
    output logic [PIX_W-1:0]       post_img_mag
);

    localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 2;
    localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 2;
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

    logic                   vsync_q, vsync_d;
    logic                   href_q, href_d;
    logic                   synced_q, synced_d;
    logic [CW-1:0]          col_q, col_d, col_cur;
    logic [RW-1:0]          row_q, row_d, row_cur;
    logic [SOBEL_MAG_W-1:0] thr_q, thr_d;
    logic [SOBEL_SUM_W-1:0] gxp_q, gxp_d, gxn_q, gxn_d;
    logic [SOBEL_SUM_W-1:0] gyp_q, gyp_d, gyn_q, gyn_d;
    logic [SOBEL_SUM_W-1:0] ax_q, ax_d, ay_q, ay_d;
    logic [SOBEL_MAG_W-1:0] mag;
    logic                   bit_q, bit_d;
    logic [PIX_W-1:0]       mag_q, mag_d;
    logic                   vs_rise, href_fall, pix_in;
    logic                   border_in, border_s2;
    sync_t                  sync_in, sync_out;

    // frame/line tracking: counters clear before the
    // current pixel is classified, so a vsync-rise pixel is col 0
    always_comb begin
        vs_rise   = matrix_frame_vsync & ~vsync_q;
        href_fall = href_q & ~matrix_frame_href;
        pix_in    = matrix_frame_href & matrix_frame_clken;
        vsync_d   = matrix_frame_vsync;
        href_d    = matrix_frame_href;
        synced_d  = synced_q | vs_rise;
        thr_d     = vs_rise ? threshold : thr_q;
        col_cur   = vs_rise ? '0 : col_q;
        row_cur   = vs_rise ? '0 : row_q;
        col_d     = col_cur;
        row_d     = row_cur;
        if (href_fall) begin
            col_d = '0;
        end else if (pix_in && col_cur != COL_MAX) begin
            col_d = col_cur + 1'b1;
        end
        if (!vs_rise && href_fall && row_q != ROW_MAX) begin
            row_d = row_q + 1'b1;
        end
        border_in = ~synced_d
                  | (col_cur < CW'(BORDER))
                  | (row_cur < RW'(BORDER));
    end

    // S1 partial sums, S2 abs diffs, S3 magnitude/threshold
    always_comb begin
        gxp_d = tap_sum(matrix_p13, matrix_p23, matrix_p33);
        gxn_d = tap_sum(matrix_p11, matrix_p21, matrix_p31);
        gyp_d = tap_sum(matrix_p31, matrix_p32, matrix_p33);
        gyn_d = tap_sum(matrix_p11, matrix_p12, matrix_p13);
        ax_d  = abs_diff(gxp_q, gxn_q);
        ay_d  = abs_diff(gyp_q, gyn_q);
        mag   = {1'b0, ax_q} + {1'b0, ay_q};
        bit_d = (mag >= thr_q) & ~border_s2;
        mag_d = '0;
        if (!border_s2) begin
            mag_d = (|mag[SOBEL_MAG_W-1:PIX_W]) ? '1 : mag[PIX_W-1:0];
        end
    end

    // state and pipeline registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q  <= 1'b0;
            href_q   <= 1'b0;
            synced_q <= 1'b0;
            col_q    <= '0;
            row_q    <= '0;
            thr_q    <= '0;
            gxp_q    <= '0;
            gxn_q    <= '0;
            gyp_q    <= '0;
            gyn_q    <= '0;
            ax_q     <= '0;
            ay_q     <= '0;
            bit_q    <= 1'b0;
            mag_q    <= '0;
        end else begin
            vsync_q  <= vsync_d;
            href_q   <= href_d;
            synced_q <= synced_d;
            col_q    <= col_d;
            row_q    <= row_d;
            thr_q    <= thr_d;
            gxp_q    <= gxp_d;
            gxn_q    <= gxn_d;
            gyp_q    <= gyp_d;
            gyn_q    <= gyn_d;
            ax_q     <= ax_d;
            ay_q     <= ay_d;
            bit_q    <= bit_d;
            mag_q    <= mag_d;
        end
    end

    assign sync_in = '{
        vsync: matrix_frame_vsync,
        href:  matrix_frame_href,
        clken: matrix_frame_clken
    };

    sync_delay_line #(.W(SYNC_W), .D(PIPE_LAT)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (sync_in),
        .q     (sync_out)
    );

    // border reaches S2 here; the S3 register adds the third clk
    sync_delay_line #(.W(1), .D(PIPE_LAT - 1)) u_border (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (border_in),
        .q     (border_s2)
    );

    assign post_frame_vsync = sync_out.vsync;
    assign post_frame_href  = sync_out.href;
    assign post_frame_clken = sync_out.clken;
    assign post_img_bit     = bit_q;
    assign post_img_mag     = mag_q;

endmodule

// File: tb/tb_sobel_edge_3x3_8bit.sv
// Directed bench for sobel_edge_3x3_8bit: per-frame
// window vectors plus threshold-latch and mid-line reset cases.
module tb_sobel_edge_3x3_8bit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        matrix_frame_vsync, matrix_frame_href, matrix_frame_clken;
    logic [7:0]  matrix_p11, matrix_p12, matrix_p13;
    logic [7:0]  matrix_p21, matrix_p22, matrix_p23;
    logic [7:0]  matrix_p31, matrix_p32, matrix_p33;
    logic [10:0] threshold;
    logic        post_frame_vsync, post_frame_href, post_frame_clken;
    logic        post_img_bit;
    logic [7:0]  post_img_mag;

    sobel_edge_3x3_8bit #(.IMG_W(8), .IMG_H(6)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .matrix_frame_vsync (matrix_frame_vsync),
        .matrix_frame_href  (matrix_frame_href),
        .matrix_frame_clken (matrix_frame_clken),
        .matrix_p11         (matrix_p11),
        .matrix_p12         (matrix_p12),
        .matrix_p13         (matrix_p13),
        .matrix_p21         (matrix_p21),
        .matrix_p22         (matrix_p22),
        .matrix_p23         (matrix_p23),
        .matrix_p31         (matrix_p31),
        .matrix_p32         (matrix_p32),
        .matrix_p33         (matrix_p33),
        .threshold          (threshold),
        .post_frame_vsync   (post_frame_vsync),
        .post_frame_href    (post_frame_href),
        .post_frame_clken   (post_frame_clken),
        .post_img_bit       (post_img_bit),
        .post_img_mag       (post_img_mag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       b;
        logic [7:0] m;
        int         c;
    } exp_t;

    typedef struct {
        logic [71:0] win;
        logic [10:0] thr;
        logic        eb;
        logic [7:0]  em;
    } vec_t;

    exp_t q[$];
    exp_t mon_e;
    vec_t vt[10];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                     name, act, req, cyc);
        end
    endtask

    // every output strobe must match the oldest pending pixel
    always @(negedge clk) begin
        if (rst_n && post_frame_clken) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_clken: got output strobe, expected none (cycle %0d)", cyc);
            end else begin
                mon_e = q.pop_front();
                chk("edge_bit", 32'(post_img_bit), 32'(mon_e.b));
                chk("edge_mag", 32'(post_img_mag), 32'(mon_e.m));
                chk("latency", 32'(cyc - mon_e.c), 32'd3);
            end
        end
    end

    initial begin
        #60000;
        $display("FAIL watchdog: got no end of test, expected finish");
        $fatal(1, "timeout");
    end

    task automatic set_win(input logic [71:0] w);
        {matrix_p11, matrix_p12, matrix_p13,
         matrix_p21, matrix_p22, matrix_p23,
         matrix_p31, matrix_p32, matrix_p33} = w;
    endtask

    task automatic drive(input logic h, input logic ce,
                         input logic b, input logic [7:0] m);
        @(posedge clk);
        #1;
        matrix_frame_vsync = 1'b0;
        matrix_frame_href  = h;
        matrix_frame_clken = ce;
        if (h && ce) q.push_back('{b: b, m: m, c: cyc});
    endtask

    task automatic vs(input logic v);
        @(posedge clk);
        #1;
        matrix_frame_vsync = v;
        matrix_frame_href  = 1'b0;
        matrix_frame_clken = 1'b0;
    endtask

    task automatic frame_start(input logic [10:0] t);
        threshold = t;
        vs(1'b1);
        vs(1'b1);
        vs(1'b0);
        vs(1'b0);
    endtask

    // 4 lines x 5 pixels, one clken gap per line
    task automatic run_frame(input logic [71:0] w, input logic [10:0] t0,
                             input logic [10:0] t1, input logic eb,
                             input logic [7:0] em);
        logic bd;
        set_win(w);
        frame_start(t0);
        for (int r = 0; r < 4; r++) begin
            if (r == 1) threshold = t1;
            for (int c = 0; c < 5; c++) begin
                if (c == 2) drive(1'b1, 1'b0, 1'b0, 8'd0);
                bd = (r < 2) || (c < 2);
                drive(1'b1, 1'b1, bd ? 1'b0 : eb, bd ? 8'd0 : em);
            end
            repeat (3) drive(1'b0, 1'b0, 1'b0, 8'd0);
        end
        repeat (4) drive(1'b0, 1'b0, 1'b0, 8'd0);
    endtask

    initial begin
        vt[0] = '{win: 72'h646464_646464_646464, thr: 11'd1,    eb: 1'b0, em: 8'd0};
        vt[1] = '{win: 72'h0080FF_0080FF_0080FF, thr: 11'd128,  eb: 1'b1, em: 8'd255};
        vt[2] = '{win: 72'h00000A_00000A_00000A, thr: 11'd40,   eb: 1'b1, em: 8'd40};
        vt[3] = '{win: 72'h00000A_00000A_00000A, thr: 11'd41,   eb: 1'b0, em: 8'd40};
        vt[4] = '{win: 72'h000000_323232_C8C8C8, thr: 11'd800,  eb: 1'b1, em: 8'd255};
        vt[5] = '{win: 72'h1E0000_000000_000000, thr: 11'd61,   eb: 1'b0, em: 8'd60};
        vt[6] = '{win: 72'h0000FF_0000FF_FFFFFF, thr: 11'd2040, eb: 1'b0, em: 8'd255};
        vt[7] = '{win: 72'h000000_00007F_000000, thr: 11'd254,  eb: 1'b1, em: 8'd254};
        vt[8] = '{win: 72'h000000_000080_000000, thr: 11'd257,  eb: 1'b0, em: 8'd255};
        vt[9] = '{win: 72'hFF0000_FF0000_FF0000, thr: 11'd1020, eb: 1'b1, em: 8'd255};

        rst_n = 1'b0;
        matrix_frame_vsync = 1'b1;
        matrix_frame_href  = 1'b1;
        matrix_frame_clken = 1'b1;
        threshold = 11'd5;
        set_win(72'h0080FF_0080FF_0080FF);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_vsync", 32'(post_frame_vsync), 32'd0);
        chk("rst_href", 32'(post_frame_href), 32'd0);
        chk("rst_clken", 32'(post_frame_clken), 32'd0);
        chk("rst_bit", 32'(post_img_bit), 32'd0);
        chk("rst_mag", 32'(post_img_mag), 32'd0);
        matrix_frame_vsync = 1'b0;
        matrix_frame_href  = 1'b0;
        matrix_frame_clken = 1'b0;
        #2 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("idle_bit", 32'(post_img_bit), 32'd0);
        chk("idle_mag", 32'(post_img_mag), 32'd0);

        for (int i = 0; i < 10; i++) begin
            run_frame(vt[i].win, vt[i].thr, vt[i].thr, vt[i].eb, vt[i].em);
        end

        // threshold edit mid-frame only lands at the next vsync rise
        run_frame(72'h00000A_00000A_00000A, 11'd1000, 11'd10, 1'b0, 8'd40);
        run_frame(72'h00000A_00000A_00000A, 11'd10, 11'd10, 1'b1, 8'd40);

        // reset pulsed in the middle of line 2 of a vertical-edge frame
        set_win(72'h0080FF_0080FF_0080FF);
        frame_start(11'd128);
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 5; c++) drive(1'b1, 1'b1, 1'b0, 8'd0);
            repeat (3) drive(1'b0, 1'b0, 1'b0, 8'd0);
        end
        for (int c = 0; c < 6; c++) begin
            drive(1'b1, 1'b1, (c < 2) ? 1'b0 : 1'b1, (c < 2) ? 8'd0 : 8'd255);
        end
        #1;
        chk("pre_rst_bit", 32'(post_img_bit), 32'd1);
        chk("pre_rst_mag", 32'(post_img_mag), 32'd255);
        rst_n = 1'b0;
        matrix_frame_clken = 1'b0;
        #1;
        chk("mid_rst_vsync", 32'(post_frame_vsync), 32'd0);
        chk("mid_rst_href", 32'(post_frame_href), 32'd0);
        chk("mid_rst_clken", 32'(post_frame_clken), 32'd0);
        chk("mid_rst_bit", 32'(post_img_bit), 32'd0);
        chk("mid_rst_mag", 32'(post_img_mag), 32'd0);
        q.delete();
        @(posedge clk);
        #3 rst_n = 1'b1;
        for (int c = 0; c < 3; c++) drive(1'b1, 1'b1, 1'b0, 8'd0);
        repeat (6) drive(1'b0, 1'b0, 1'b0, 8'd0);
        run_frame(72'h0080FF_0080FF_0080FF, 11'd128, 11'd128, 1'b1, 8'd255);

        chk("pending_at_end", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
